// File: rtl/i_mem_pkg.sv
// Shared constants, request/response types and byte-merge helper for the i_mem_pipe block.
package i_mem_pkg;

  localparam int unsigned I_MEM_DATA_WIDTH   = 128;
  localparam int unsigned I_MEM_DEPTH        = 1024;
  localparam int unsigned I_MEM_ADRS_WIDTH   = $clog2(I_MEM_DEPTH);
  localparam int unsigned I_MEM_READ_LATENCY = 2;
  localparam int unsigned I_MEM_TAG_WIDTH    = 4;

  typedef struct packed {
    logic [I_MEM_ADRS_WIDTH-1:0] addr;
    logic [I_MEM_TAG_WIDTH-1:0]  tag;
  } t_i_mem_req;

  typedef struct packed {
    logic [I_MEM_DATA_WIDTH-1:0] data;
    logic [I_MEM_TAG_WIDTH-1:0]  tag;
    logic                        err;
  } t_i_mem_rsp;

  // Per-byte merge keeps the helper independent of the line width.
  function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                          input logic [7:0] new_byte,
                                          input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/i_mem_rsp_fifo.sv
// Synchronous FIFO for tagged responses; any depth >= 2, async active-low reset.
module i_mem_rsp_fifo #(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  logic [Width-1:0]    store_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                push_ok, pop_ok;

  assign full_o  = (count_q == CntWidth'(Depth));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = store_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      store_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/i_mem_pipe.sv
// Pipelined instruction memory: tagged in-order line reads with credit flow control and a
// byte-enabled write port. Define I_MEM_WR_BYPASS_EN to forward same-edge writes to reads.
module i_mem_pipe
  import i_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = I_MEM_DATA_WIDTH,
  parameter int unsigned DEPTH        = I_MEM_DEPTH,
  parameter int unsigned ADRS_WIDTH   = $clog2(DEPTH),
  parameter int unsigned READ_LATENCY = I_MEM_READ_LATENCY,
  parameter int unsigned TAG_WIDTH    = I_MEM_TAG_WIDTH
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADRS_WIDTH-1:0]   req_addr,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  output logic                    rsp_err,
  input  logic                    wr_en,
  input  logic [ADRS_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be
);

  localparam int unsigned BeWidth     = DATA_WIDTH / 8;
  localparam int unsigned RspDepth    = READ_LATENCY + 1;
  localparam int unsigned CreditWidth = $clog2(RspDepth + 1);
  localparam int unsigned PayWidth    = DATA_WIDTH + TAG_WIDTH + 1;
  localparam logic [ADRS_WIDTH:0] DepthExt = (ADRS_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    rd_in_range, wr_in_range;
  logic                    req_fire, rsp_pop;
  logic                    fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]   rd_line, wr_line;
  logic [CreditWidth-1:0]  credit_q, credit_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [PayWidth-1:0]     pipe_pay_q [READ_LATENCY];
  logic [PayWidth-1:0]     pipe_pay_d [READ_LATENCY];
  logic [PayWidth-1:0]     fifo_head;

  assign rd_in_range = ({1'b0, req_addr} < DepthExt);
  assign wr_in_range = ({1'b0, wr_addr} < DepthExt);

  // Credits cover in-flight reads plus FIFO occupancy, so the FIFO cannot overflow.
  // fifo_full is implied by the credit limit; it only restates that from registered state.
  assign req_ready = (credit_q < CreditWidth'(RspDepth)) && !fifo_full;
  assign req_fire  = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  always_comb begin
    wr_line = mem_q[wr_addr];
    for (int i = 0; i < BeWidth; i++) begin
      wr_line[8*i +: 8] = be_merge(mem_q[wr_addr][8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
    end
  end

  always_comb begin
    rd_line = '0;
    if (rd_in_range) begin
`ifdef I_MEM_WR_BYPASS_EN
      if (wr_en && (wr_addr == req_addr)) begin
        rd_line = wr_line;
      end else begin
        rd_line = mem_q[req_addr];
      end
`else
      rd_line = mem_q[req_addr];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && wr_in_range) begin
      mem_q[wr_addr] <= wr_line;
    end
  end

  always_comb begin
    pipe_vld_d[0] = req_fire;
    pipe_pay_d[0] = {rd_line, req_tag, !rd_in_range};
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_pay_d[i] = pipe_pay_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < READ_LATENCY; i++) begin
      pipe_pay_q[i] <= pipe_pay_d[i];
    end
  end

  always_comb begin
    case ({req_fire, rsp_pop})
      2'b10:   credit_d = credit_q + CreditWidth'(1);
      2'b01:   credit_d = credit_q - CreditWidth'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  i_mem_rsp_fifo #(
    .Depth (RspDepth),
    .Width (PayWidth)
  ) u_rsp_fifo (
    .clk_i   (clock),
    .rst_ni  (rst_n),
    .push_i  (pipe_vld_q[READ_LATENCY-1]),
    .data_i  (pipe_pay_q[READ_LATENCY-1]),
    .pop_i   (rsp_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs are zeroed when empty so a drained or reset FIFO shows no stale payload.
  always_comb begin
    {rsp_data, rsp_tag, rsp_err} = '0;
    if (!fifo_empty) begin
      {rsp_data, rsp_tag, rsp_err} = fifo_head;
    end
  end

endmodule
